router_input_port: RTL and testbench

ROUTER_INPUT_PORT -- requirements
Module: router_input_port

---
 rtl/router_input_port.sv | 92 +++++++++
 tb/tb_router_input_port.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/router_input_port.sv
// Router input port: two single-packet virtual-channel buffers selected by the
// router-global polarity, with dimension-order routing and hop-count update.
module router_input_port #(
   parameter int PACKET_WIDTH = 64,
   parameter int HOP_W        = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    polarity,
   input  logic                    si,
   output logic                    ri,
   input  logic [PACKET_WIDTH-1:0] di,
   output logic [4:0]              req,
   input  logic                    gnt,
   output logic [PACKET_WIDTH-1:0] dout,
   output logic [1:0]              vc_full
);

   // Packet bit 0 is the MSB, so packet bit i lives at vector index PACKET_WIDTH-1-i.
   // hx/hy are the two HOP_W-wide fields at the LSB end; hy is the last one.
   localparam int XDIR_IDX = PACKET_WIDTH - 2;
   localparam int YDIR_IDX = PACKET_WIDTH - 3;
   localparam int HX_LO    = HOP_W;
   localparam int HY_LO    = 0;

   // req vector index 4 is port 0 (N) ... index 0 is port 4 (PE).
   localparam logic [4:0] REQ_N  = 5'b10000;
   localparam logic [4:0] REQ_S  = 5'b01000;
   localparam logic [4:0] REQ_E  = 5'b00100;
   localparam logic [4:0] REQ_W  = 5'b00010;
   localparam logic [4:0] REQ_PE = 5'b00001;

   // Upstream handshake: a packet moves on a rising edge where si and ri are both
   // high; si while ri is low is dropped silently. Downstream: the held packet
   // leaves on a rising edge where gnt is high and req is non-zero.
   logic [1:0]              full_q;
   logic [PACKET_WIDTH-1:0] buf_q [2];

   logic                    wr_vc;
   logic                    rd_vc;
   logic [PACKET_WIDTH-1:0] rd_buf;
   logic [HOP_W-1:0]        hx;
   logic [HOP_W-1:0]        hy;
   logic                    accept;
   logic                    release_rd;

   assign wr_vc      = polarity;
   assign rd_vc      = ~polarity;
   assign rd_buf     = buf_q[rd_vc];
   assign hx         = rd_buf[HX_LO +: HOP_W];
   assign hy         = rd_buf[HY_LO +: HOP_W];
   assign ri         = ~full_q[wr_vc];
   assign accept     = si & ri;
   assign release_rd = gnt & (req != 5'b00000);
   // vc_full index 1 is VC0, index 0 is VC1.
   assign vc_full    = {full_q[0], full_q[1]};

   always_comb begin
      req  = 5'b00000;
      dout = '0;
      if (full_q[rd_vc]) begin
         dout = rd_buf;
         if (hx != '0) begin
            req                   = rd_buf[XDIR_IDX] ? REQ_W : REQ_E;
            dout[HX_LO +: HOP_W]  = hx - 1'b1;
         end else if (hy != '0) begin
            req                   = rd_buf[YDIR_IDX] ? REQ_S : REQ_N;
            dout[HY_LO +: HOP_W]  = hy - 1'b1;
         end else begin
            req                   = REQ_PE;
         end
      end
   end

   // Write and release always target opposite VCs, so both may fire together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         full_q   <= 2'b00;
         buf_q[0] <= '0;
         buf_q[1] <= '0;
      end else begin
         if (accept) begin
            buf_q[wr_vc]  <= di;
            full_q[wr_vc] <= 1'b1;
         end
         if (release_rd) begin
            full_q[rd_vc] <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_router_input_port.sv
// Bench for router_input_port: a queue-based reference model feeds expected
// outputs to a scoreboard; a separate monitor pops and compares every cycle.
module tb_router_input_port;

   localparam int PW = 64;
   localparam int HW = 8;
   localparam int W  = 1 + 2 + 5 + PW;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          polarity = 1'b0;
   logic          si = 1'b0;
   logic          ri;
   logic [PW-1:0] di = '0;
   logic [4:0]    req;
   logic          gnt = 1'b0;
   logic [PW-1:0] dout;
   logic [1:0]    vc_full;

   int total = 0;
   int bad   = 0;
   bit done  = 1'b0;

   logic [W-1:0]  exp_q[$];

   bit            m_full [2];
   logic [PW-1:0] m_buf  [2];

   router_input_port #(.PACKET_WIDTH(PW), .HOP_W(HW)) dut (
      .clk(clk), .reset(reset), .polarity(polarity), .si(si), .ri(ri),
      .di(di), .req(req), .gnt(gnt), .dout(dout), .vc_full(vc_full)
   );

   always #5 clk = ~clk;

   // Packet bits are numbered from the MSB (bit 0).
   function automatic bit pbit(input logic [PW-1:0] p, input int n);
      return p[PW-1-n];
   endfunction

   function automatic int get_field(input logic [PW-1:0] p, input int first);
      int v = 0;
      for (int i = 0; i < HW; i++) v = v * 2 + int'(pbit(p, first + i));
      return v;
   endfunction

   function automatic logic [PW-1:0] set_field(input logic [PW-1:0] p, input int first, input int v);
      logic [PW-1:0] r = p;
      for (int i = 0; i < HW; i++) r[PW-1-(first+i)] = 1'((v >> (HW-1-i)) & 1);
      return r;
   endfunction

   function automatic logic [PW-1:0] make_pkt(input bit xd, input bit yd, input int hxv, input int hyv);
      logic [PW-1:0] p = {$urandom, $urandom};
      p[PW-1-1] = xd;
      p[PW-1-2] = yd;
      p = set_field(p, PW - 2*HW, hxv);
      p = set_field(p, PW - HW, hyv);
      return p;
   endfunction

   // Port numbers 0..4 = N,S,E,W,PE; req written MSB-first puts port 0 leftmost.
   function automatic logic [4:0] port_req(input int port);
      logic [4:0] one = 5'b10000;
      return one >> port;
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got ri=%b vc_full=%b req=%b dout=%h, want ri=%b vc_full=%b req=%b dout=%h",
                  name, act[W-1], act[W-2 -: 2], act[W-4 -: 5], act[PW-1:0],
                  expv[W-1], expv[W-2 -: 2], expv[W-4 -: 5], expv[PW-1:0]);
      end
   endtask

   // One clock cycle of stimulus: drive, predict outputs, then advance the model.
   task automatic cycle(input bit rst, input bit pol, input bit s, input logic [PW-1:0] d, input bit g);
      int            rd;
      int            hxv;
      int            hyv;
      logic [4:0]    e_req;
      logic [PW-1:0] e_dout;
      bit            e_ri;
      @(negedge clk);
      reset = rst; polarity = pol; si = s; di = d; gnt = g;
      if (rst) begin
         m_full[0] = 0; m_full[1] = 0; m_buf[0] = '0; m_buf[1] = '0;
      end
      rd     = pol ? 0 : 1;
      e_ri   = !m_full[pol];
      e_req  = 5'b00000;
      e_dout = '0;
      if (m_full[rd]) begin
         hxv    = get_field(m_buf[rd], PW - 2*HW);
         hyv    = get_field(m_buf[rd], PW - HW);
         e_dout = m_buf[rd];
         if (hxv != 0) begin
            e_req  = port_req(pbit(m_buf[rd], 1) ? 3 : 2);
            e_dout = set_field(e_dout, PW - 2*HW, hxv - 1);
         end else if (hyv != 0) begin
            e_req  = port_req(pbit(m_buf[rd], 2) ? 1 : 0);
            e_dout = set_field(e_dout, PW - HW, hyv - 1);
         end else begin
            e_req  = port_req(4);
         end
      end
      exp_q.push_back({e_ri, m_full[0], m_full[1], e_req, e_dout});
      if (!rst) begin
         if (g && m_full[rd]) m_full[rd] = 0;
         if (s && e_ri) begin
            m_buf[pol]  = d;
            m_full[pol] = 1;
         end
      end
   endtask

   // Raise reset between clock edges while packets are buffered.
   task automatic async_reset_check();
      @(posedge clk);
      #2 reset = 1'b1;
      #1 check("async_reset", {ri, vc_full, req, dout}, {1'b1, 2'b00, 5'b00000, {PW{1'b0}}});
      m_full[0] = 0; m_full[1] = 0; m_buf[0] = '0; m_buf[1] = '0;
   endtask

   initial begin : monitor
      logic [W-1:0] e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() == 0) begin
            if (!done) begin
               total++; bad++;
               $display("FAIL sb_underflow: got empty queue, want an expected entry");
            end
         end else begin
            e = exp_q.pop_front();
            check("scoreboard", {ri, vc_full, req, dout}, e);
         end
      end
   end

   initial begin : stimulus
      logic [PW-1:0] p;
      m_full[0] = 0; m_full[1] = 0; m_buf[0] = '0; m_buf[1] = '0;

      // Reset held, si high on the reset edge must not capture.
      cycle(1, 0, 1, make_pkt(0, 0, 2, 0), 0);
      cycle(1, 0, 1, make_pkt(0, 0, 2, 0), 0);
      // East route, hx 2 -> 1, then full VC0 refuses a new write.
      cycle(0, 0, 1, make_pkt(0, 0, 2, 0), 0);
      cycle(0, 1, 0, '0, 0);
      cycle(0, 0, 1, make_pkt(1, 1, 5, 5), 0);
      cycle(0, 1, 0, '0, 0);
      // South route with simultaneous grant on VC0 and write on VC1.
      cycle(1, 0, 0, '0, 0);
      cycle(0, 0, 1, make_pkt(0, 1, 0, 3), 0);
      cycle(0, 1, 1, make_pkt(1, 0, 1, 0), 1);
      cycle(0, 1, 0, '0, 0);
      cycle(0, 0, 0, '0, 1);
      // PE route: dout equals the stored packet exactly; West and North too.
      cycle(0, 1, 1, make_pkt(0, 0, 0, 0), 0);
      cycle(0, 0, 1, make_pkt(1, 0, 255, 0), 0);
      cycle(0, 1, 0, '0, 1);
      cycle(0, 0, 0, '0, 1);
      cycle(0, 1, 1, make_pkt(0, 0, 0, 1), 0);
      cycle(0, 0, 0, '0, 1);
      // Both VCs full, then asynchronous reset mid-cycle.
      cycle(0, 0, 1, make_pkt(0, 0, 1, 1), 0);
      cycle(0, 1, 1, make_pkt(1, 1, 0, 2), 0);
      async_reset_check();
      cycle(1, 0, 1, make_pkt(0, 0, 1, 0), 0);
      // Grant held with both VCs empty.
      for (int i = 0; i < 10; i++) cycle(0, i[0], 0, '0, 1);
      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         p = make_pkt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 3)),
                      ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 3)));
         cycle(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 9) < 7), p, 1'($urandom_range(0, 1)));
      end
      #3;
      done = 1'b1;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL sb_drain: got %0d entries left, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
